// File: rtl/ucb_arbiter_if.sv
// Bundles the PE request/grant lines and the UCB read port shared by the arbiter.
// master = arbiter side, slave = PEs plus buffer.
interface ucb_arbiter_if #(
  parameter int NUM_PE = 4,
  parameter int DATA_W = 36
);
  logic [NUM_PE:1]   ucb_req;
  logic [NUM_PE:1]   ucb_gnt;
  logic [DATA_W-1:0] clause_out;
  logic              clause_empty;
  logic              buf_empty;
  logic              buf_rd;
  logic [DATA_W-1:0] buf_rd_data;
  logic              buf_rd_valid;
  logic              rd_err;

  modport master (
    input  ucb_req, buf_empty, buf_rd_data, buf_rd_valid,
    output ucb_gnt, clause_out, clause_empty, buf_rd, rd_err
  );

  modport slave (
    output ucb_req, buf_empty, buf_rd_data, buf_rd_valid,
    input  ucb_gnt, clause_out, clause_empty, buf_rd, rd_err
  );
endinterface

// File: rtl/ucb_arbiter.sv
// Round-robin sequencer sharing the unsatisfied clause buffer among NUM_PE processing elements.
// One transaction at a time: pick a PE, pop the buffer, wait for data, pulse a one-hot grant.
module ucb_arbiter #(
  parameter int NUM_PE  = 4,
  parameter int DATA_W  = 36,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  ucb_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GRANT = 2'd3;

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  winner;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] clause_q;
  logic              empty_q;
  logic              err_q;
  logic [NUM_PE:1]   gnt;

  // First requester at or after 'start', wrapping; index is 0-based (PE1 -> 0).
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_PE-1:0] req,
                                               input logic [PTR_W-1:0]  start);
    logic [PTR_W-1:0]  sel;
    logic              found;
    logic [NUM_PE-1:0] rot;
    int                idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PE; k++) begin
      idx = (int'(start) + k) % NUM_PE;
      rot = req >> idx;
      if (!found && rot[0]) begin
        sel   = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      winner   <= '0;
      cnt      <= '0;
      clause_q <= '0;
      empty_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ucb_req != '0) begin
            winner <= rr_pick(bus.ucb_req, ptr);
            if (bus.buf_empty) begin
              clause_q <= '0;
              empty_q  <= 1'b1;
              state    <= S_GRANT;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.buf_rd_valid) begin
            clause_q <= bus.buf_rd_data;
            empty_q  <= 1'b0;
            state    <= S_GRANT;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Abandon the read without touching ptr so the same PE keeps priority.
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          ptr   <= (winner == PTR_W'(NUM_PE - 1)) ? '0 : winner + 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 1; i <= NUM_PE; i++) begin
      if (state == S_GRANT && winner == PTR_W'(i - 1)) gnt[i] = 1'b1;
    end
  end

  assign bus.ucb_gnt      = gnt;
  assign bus.buf_rd       = (state == S_READ);
  assign bus.clause_out   = clause_q;
  assign bus.clause_empty = empty_q;
  assign bus.rd_err       = err_q;

endmodule

// File: tb/tb_ucb_arbiter.sv
// Bench for ucb_arbiter: directed scenarios plus randomized transactions against a
// transaction-level round-robin model.
module tb_ucb_arbiter;
  localparam int NUM_PE  = 4;
  localparam int DATA_W  = 36;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ucb_arbiter_if #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) bus ();

  ucb_arbiter #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  function automatic int model_pick(input logic [4:1] req, input int ptr);
    for (int k = 0; k < NUM_PE; k++) begin
      int pe;
      pe = ((ptr + k) % NUM_PE) + 1;
      if (req[pe]) return pe;
    end
    return 0;
  endfunction

  function automatic logic [4:1] onehot(input int pe);
    logic [4:1] v;
    v = '0;
    if (pe >= 1 && pe <= NUM_PE) v = 4'(1) << (pe - 1);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    bus.ucb_req = '0;
    bus.buf_rd_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Called during an IDLE cycle (cycle 0); ends during the next IDLE cycle.
  task automatic do_txn(input logic [4:1] req, input bit empty, input int lat,
                        input logic [35:0] data, input bit spur, input bit drop,
                        output logic [4:1] gnt, output int gcyc, output int rd_cnt,
                        output int rd_cyc, output logic [35:0] cout, output bit cempty,
                        output logic [4:1] gnt_after, output logic [35:0] cout_after,
                        output int err_cyc, output int multi);
    int vcyc;
    bit got;
    gnt = '0; gcyc = -1; rd_cnt = 0; rd_cyc = -1; cout = '0; cempty = 1'b0;
    gnt_after = '0; cout_after = '0; err_cyc = -1; multi = 0; vcyc = -1; got = 1'b0;
    bus.ucb_req = req;
    bus.buf_empty = empty;
    bus.buf_rd_valid = 1'b0;
    for (int c = 1; c <= TIMEOUT + 6; c++) begin
      step();
      bus.buf_rd_valid = (c == vcyc) || (spur && c == 1);
      bus.buf_rd_data  = (c == vcyc) ? data : 36'hF_DEAD_BEEF;
      if (drop && c == 1) bus.ucb_req = '0;
      if (got) begin
        gnt_after  = bus.ucb_gnt;
        cout_after = bus.clause_out;
        break;
      end
      if ($countones(bus.ucb_gnt) > 1) multi++;
      if (bus.buf_rd) begin
        rd_cnt++;
        rd_cyc = c;
        if (lat > 0) vcyc = c + lat;
      end
      if (bus.rd_err && err_cyc < 0) err_cyc = c;
      if (bus.ucb_gnt != '0) begin
        got    = 1'b1;
        gnt    = bus.ucb_gnt;
        gcyc   = c;
        cout   = bus.clause_out;
        cempty = bus.clause_empty;
      end
      if (lat == 0 && !empty && c == TIMEOUT + 2) break;
    end
    bus.buf_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.ucb_req = 4'b1111;
    bus.buf_empty = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bus.ucb_gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus.ucb_gnt); end
      total++; if (bus.buf_rd !== 1'b0) begin bad++; $display("FAIL reset_buf_rd: got %b want 0", bus.buf_rd); end
      total++; if (bus.rd_err !== 1'b0) begin bad++; $display("FAIL reset_rd_err: got %b want 0", bus.rd_err); end
    end
    total++; if (bus.clause_out !== 36'h0) begin bad++; $display("FAIL reset_clause: got %h want 0", bus.clause_out); end
    total++; if (bus.clause_empty !== 1'b0) begin bad++; $display("FAIL reset_empty: got %b want 0", bus.clause_empty); end
    bus.ucb_req = '0;
    rst = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_fairness();
    logic [4:1] g, ga; logic [35:0] co, coa; bit ce; int gc, rc, rcy, ec, mu, pe;
    for (int n = 0; n < 5; n++) begin
      pe = model_pick(4'b1111, m_ptr);
      do_txn(4'b1111, 1'b0, 1, 36'(n + 36'h100), 1'b0, 1'b0, g, gc, rc, rcy, co, ce, ga, coa, ec, mu);
      total++; if (g !== onehot(pe)) begin bad++; $display("FAIL fair_gnt[%0d]: got %b want %b", n, g, onehot(pe)); end
      total++; if (rc !== 1) begin bad++; $display("FAIL fair_rd_cnt[%0d]: got %0d want 1", n, rc); end
      total++; if (gc !== 3) begin bad++; $display("FAIL fair_latency[%0d]: got %0d want 3", n, gc); end
      m_ptr = pe % NUM_PE;
    end
    bus.ucb_req = '0;
  endtask

  task automatic test_single();
    logic [4:1] g, ga; logic [35:0] co, coa; bit ce; int gc, rc, rcy, ec, mu;
    do_txn(4'b0100, 1'b0, 2, 36'h0_1234_ABCD, 1'b0, 1'b0, g, gc, rc, rcy, co, ce, ga, coa, ec, mu);
    total++; if (g !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", g); end
    total++; if (gc !== 4) begin bad++; $display("FAIL single_cycle: got %0d want 4", gc); end
    total++; if (rc !== 1 || rcy !== 1) begin bad++; $display("FAIL single_buf_rd: got cnt=%0d cyc=%0d want cnt=1 cyc=1", rc, rcy); end
    total++; if (co !== 36'h0_1234_ABCD) begin bad++; $display("FAIL single_clause: got %h want 012345abcd", co); end
    total++; if (ce !== 1'b0) begin bad++; $display("FAIL single_empty: got %b want 0", ce); end
    total++; if (ga !== 4'b0000) begin bad++; $display("FAIL single_pulse: got %b want 0000", ga); end
    m_ptr = 3 % NUM_PE;
    bus.ucb_req = '0;
  endtask

  task automatic test_empty();
    logic [4:1] g, ga; logic [35:0] co, coa; bit ce; int gc, rc, rcy, ec, mu;
    do_txn(4'b0010, 1'b1, 0, 36'h0, 1'b0, 1'b0, g, gc, rc, rcy, co, ce, ga, coa, ec, mu);
    total++; if (g !== 4'b0010) begin bad++; $display("FAIL empty_gnt: got %b want 0010", g); end
    total++; if (gc !== 1) begin bad++; $display("FAIL empty_cycle: got %0d want 1", gc); end
    total++; if (ce !== 1'b1) begin bad++; $display("FAIL empty_flag: got %b want 1", ce); end
    total++; if (co !== 36'h0) begin bad++; $display("FAIL empty_clause: got %h want 0", co); end
    total++; if (rc !== 0) begin bad++; $display("FAIL empty_buf_rd: got %0d want 0", rc); end
    m_ptr = 2 % NUM_PE;
    bus.ucb_req = '0;
    bus.buf_empty = 1'b0;
  endtask

  task automatic test_timeout();
    logic [4:1] g, ga; logic [35:0] co, coa; bit ce; int gc, rc, rcy, ec, mu, pe;
    apply_reset();
    m_ptr = 0;
    do_txn(4'b0001, 1'b0, 0, 36'h0, 1'b0, 1'b0, g, gc, rc, rcy, co, ce, ga, coa, ec, mu);
    total++; if (g !== 4'b0000) begin bad++; $display("FAIL timeout_no_gnt: got %b want 0000", g); end
    total++; if (rc !== 1) begin bad++; $display("FAIL timeout_buf_rd: got %0d want 1", rc); end
    total++; if (ec !== TIMEOUT + 2) begin bad++; $display("FAIL timeout_err_cycle: got %0d want %0d", ec, TIMEOUT + 2); end
    pe = model_pick(4'b1111, m_ptr);
    do_txn(4'b1111, 1'b0, 1, 36'h5_5555_0001, 1'b0, 1'b0, g, gc, rc, rcy, co, ce, ga, coa, ec, mu);
    total++; if (g !== onehot(pe)) begin bad++; $display("FAIL timeout_ptr_kept: got %b want %b", g, onehot(pe)); end
    total++; if (bus.rd_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", bus.rd_err); end
    m_ptr = pe % NUM_PE;
    bus.ucb_req = '0;
  endtask

  task automatic test_reset_mid_wait();
    logic [4:1] g, ga; logic [35:0] co, coa; bit ce; int gc, rc, rcy, ec, mu, pe;
    bus.ucb_req = 4'b0100;
    bus.buf_empty = 1'b0;
    step();
    total++; if (bus.buf_rd !== 1'b1) begin bad++; $display("FAIL midwait_buf_rd: got %b want 1", bus.buf_rd); end
    step();
    step();
    rst = 1'b0;
    bus.ucb_req = '0;
    step();
    rst = 1'b1;
    bus.buf_rd_valid = 1'b1;
    bus.buf_rd_data = 36'h3_CAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.ucb_gnt !== 4'b0000 || bus.buf_rd !== 1'b0) begin
        bad++; $display("FAIL midwait_quiet[%0d]: got gnt=%b rd=%b want gnt=0000 rd=0", i, bus.ucb_gnt, bus.buf_rd);
      end
      step();
      bus.buf_rd_valid = 1'b0;
    end
    total++; if (bus.rd_err !== 1'b0) begin bad++; $display("FAIL midwait_rd_err: got %b want 0", bus.rd_err); end
    total++; if (bus.clause_out !== 36'h0) begin bad++; $display("FAIL midwait_clause: got %h want 0", bus.clause_out); end
    m_ptr = 0;
    pe = model_pick(4'b1111, m_ptr);
    do_txn(4'b1111, 1'b0, 1, 36'h0_0000_00AA, 1'b0, 1'b0, g, gc, rc, rcy, co, ce, ga, coa, ec, mu);
    total++; if (g !== onehot(pe)) begin bad++; $display("FAIL midwait_ptr: got %b want %b", g, onehot(pe)); end
    m_ptr = pe % NUM_PE;
    bus.ucb_req = '0;
  endtask

  task automatic test_random();
    logic [4:1] g, ga, req; logic [35:0] co, coa, data, ecout; logic [63:0] r64;
    bit ce, empty, spur, drop; int gc, rc, rcy, ec, mu, pe, lat, egc, erd;
    for (int n = 0; n < 30; n++) begin
      req   = 4'($urandom_range(15, 1));
      empty = ($urandom_range(3, 0) == 0);
      lat   = $urandom_range(TIMEOUT, 1);
      r64   = {$urandom(), $urandom()};
      data  = r64[35:0];
      spur  = 1'($urandom_range(1, 0));
      drop  = ($urandom_range(3, 0) == 0);
      pe    = model_pick(req, m_ptr);
      egc   = empty ? 1 : lat + 2;
      erd   = empty ? 0 : 1;
      ecout = empty ? 36'h0 : data;
      do_txn(req, empty, lat, data, spur, drop, g, gc, rc, rcy, co, ce, ga, coa, ec, mu);
      total++; if (g !== onehot(pe)) begin bad++; $display("FAIL rand_gnt[%0d]: got %b want %b (req %b)", n, g, onehot(pe), req); end
      total++; if (gc !== egc) begin bad++; $display("FAIL rand_cycle[%0d]: got %0d want %0d", n, gc, egc); end
      total++; if (rc !== erd) begin bad++; $display("FAIL rand_buf_rd[%0d]: got %0d want %0d", n, rc, erd); end
      total++; if (co !== ecout || ce !== empty) begin
        bad++; $display("FAIL rand_clause[%0d]: got %h/%b want %h/%b", n, co, ce, ecout, empty);
      end
      total++; if (ga !== 4'b0000 || coa !== ecout) begin
        bad++; $display("FAIL rand_after[%0d]: got gnt=%b clause=%h want gnt=0000 clause=%h", n, ga, coa, ecout);
      end
      total++; if (mu !== 0) begin bad++; $display("FAIL rand_onehot[%0d]: got %0d multi-bit cycles want 0", n, mu); end
      m_ptr = pe % NUM_PE;
    end
    bus.ucb_req = '0;
    bus.buf_empty = 1'b0;
  endtask

  initial begin
    bus.ucb_req      = '0;
    bus.buf_empty    = 1'b0;
    bus.buf_rd_data  = '0;
    bus.buf_rd_valid = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_empty();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
